// File: rtl/bram_stream_reader_pkg.sv
// bram_stream_pkg: shared types and constants for the BRAM stream reader.
//   rd_state_t     - reader FSM state (IDLE, READ)
//   PREFETCH_DEPTH - prefetch FIFO entries; also the outstanding-read limit
package bram_stream_pkg;

    typedef enum logic {IDLE, READ} rd_state_t;

    localparam int unsigned PREFETCH_DEPTH = 3;

endpackage

// File: rtl/bram_stream_reader_if.sv
// bram_stream_reader_if: BRAM read port plus output stream of the reader.
//   ram_en_o   - BRAM read enable            (reader -> BRAM)
//   ram_addr_o - BRAM read address           (reader -> BRAM)
//   ram_data_i - BRAM read data, 1-cycle lat (BRAM -> reader)
//   data_o     - stream data                 (reader -> sink)
//   valid_o    - stream valid                (reader -> sink)
//   last_o     - final word of a transfer    (reader -> sink)
//   ready_i    - stream ready                (sink -> reader)
// master: the reader side; slave: the BRAM/sink side.
interface bram_stream_reader_if #(
    parameter int RAM_WIDTH     = 8,
    parameter int RAM_ADDR_BITS = 10
);
    logic                     ram_en_o;
    logic [RAM_ADDR_BITS-1:0] ram_addr_o;
    logic [RAM_WIDTH-1:0]     ram_data_i;
    logic [RAM_WIDTH-1:0]     data_o;
    logic                     valid_o;
    logic                     last_o;
    logic                     ready_i;

    modport master (
        output ram_en_o, ram_addr_o,
        input  ram_data_i,
        output data_o, valid_o, last_o,
        input  ready_i
    );

    modport slave (
        input  ram_en_o, ram_addr_o,
        output ram_data_i,
        input  data_o, valid_o, last_o,
        output ready_i
    );
endinterface

// File: rtl/bram_stream_reader_fifo.sv
// bram_rd_fifo: small synchronous FIFO absorbing the BRAM read latency.
//   clk_i, rst_i - clock, asynchronous active-high reset
//   push_i       - write wdata_i this edge
//   pop_i        - drop the head this edge
//   rdata_o      - head entry (0 while empty)
//   count_o      - number of stored entries
//   empty_o      - no entries
//   full_o       - DEPTH entries stored
module bram_rd_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 3,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o,
    output logic             full_o
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty_o   = (r_count == '0);
    assign full_o    = (r_count == CW'(DEPTH));
    assign count_o   = r_count;
    assign w_do_pop  = pop_i & ~empty_o;
    // A push while full is only safe when the head leaves on the same edge.
    assign w_do_push = push_i & (~full_o | w_do_pop);
    // Head is masked while empty so stale entries never reach the output.
    assign rdata_o   = empty_o ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: sweeps an address range through a BRAM read port and
// presents the words as a valid/ready stream with backpressure.
//   clk_i       - clock shared with the BRAM read port
//   rst_i       - asynchronous active-high reset
//   start_i     - start command, accepted only while idle
//   base_addr_i - first address, sampled with an accepted start
//   len_i       - word count 0..DEPTH, sampled with an accepted start
//   busy_o      - transfer in progress
//   done_o      - one-cycle pulse after the final handshake / zero-length start
//   bus         - BRAM read port and output stream (master modport)
module bram_stream_reader
    import bram_stream_pkg::*;
#(
    parameter int RAM_WIDTH     = 8,
    parameter int RAM_ADDR_BITS = 10
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [RAM_ADDR_BITS-1:0] base_addr_i,
    input  logic [RAM_ADDR_BITS:0]   len_i,
    output logic                     busy_o,
    output logic                     done_o,
    bram_stream_reader_if.master     bus
);
    localparam int CNT_W = $clog2(PREFETCH_DEPTH + 1);
    localparam logic [CNT_W:0] OCC_LIMIT = (CNT_W + 1)'(PREFETCH_DEPTH);

    rd_state_t                r_state;
    rd_state_t                w_next_state;
    logic [RAM_ADDR_BITS:0]   r_req_left;
    logic [RAM_ADDR_BITS:0]   r_out_left;
    logic [RAM_ADDR_BITS-1:0] r_addr;
    logic                     r_inflight;
    logic                     r_done;

    logic                     w_start_idle;
    logic                     w_issue;
    logic                     w_pop;
    logic                     w_last_hs;
    logic [CNT_W-1:0]         w_fifo_count;
    logic [CNT_W:0]           w_occ;
    logic                     w_fifo_empty;
    logic                     w_fifo_full;
    logic [RAM_WIDTH-1:0]     w_fifo_rdata;

    bram_rd_fifo #(
        .WIDTH (RAM_WIDTH),
        .DEPTH (PREFETCH_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (r_inflight),
        .wdata_i (bus.ram_data_i),
        .pop_i   (w_pop),
        .rdata_o (w_fifo_rdata),
        .count_o (w_fifo_count),
        .empty_o (w_fifo_empty),
        .full_o  (w_fifo_full)
    );

    assign w_start_idle = (r_state == IDLE) & start_i;
    // Stored words plus the read still in flight; bounds outstanding reads
    // so the FIFO can never overflow, independent of ready_i.
    assign w_occ        = (CNT_W + 1)'(w_fifo_count) + (CNT_W + 1)'(r_inflight);

    assign bus.valid_o  = ~w_fifo_empty;
    assign bus.data_o   = w_fifo_rdata;
    assign bus.last_o   = bus.valid_o & (r_out_left == (RAM_ADDR_BITS + 1)'(1));
    assign bus.ram_addr_o = r_addr;
    assign bus.ram_en_o = w_issue;
    assign w_pop        = bus.valid_o & bus.ready_i;
    assign w_last_hs    = w_pop & bus.last_o;
    assign done_o       = r_done;

    // FSM: state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM: next state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (start_i && (len_i != '0)) w_next_state = READ;
            READ: if (w_last_hs)                w_next_state = IDLE;
            default:                            w_next_state = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy_o  = (r_state == READ);
        w_issue = (r_state == READ) && (r_req_left != '0)
                  && (w_occ < OCC_LIMIT) && !w_fifo_full;
    end

    // Counters, address generator, in-flight flag and done pulse
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_req_left <= '0;
            r_out_left <= '0;
            r_addr     <= '0;
            r_inflight <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            if (w_start_idle) begin
                r_req_left <= len_i;
                r_out_left <= len_i;
                r_addr     <= base_addr_i;
            end else begin
                if (w_issue) begin
                    r_req_left <= r_req_left - 1'b1;
                    r_addr     <= r_addr + 1'b1;
                end
                if (w_pop) begin
                    r_out_left <= r_out_left - 1'b1;
                end
            end
            // The read issued this cycle returns on the next edge and is
            // pushed into the FIFO then.
            r_inflight <= w_issue;
            r_done     <= (w_start_idle && (len_i == '0)) || w_last_hs;
        end
    end
endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Read-side companion for the simple dual-port BRAM: on a start command it sweeps an address range through the BRAM read port (enable + address, one-cycle registered read latency) and presents the words as a valid/ready stream with backpressure. It sits directly downstream of the BRAM read port and absorbs the read latency in a small prefetch FIFO, so full throughput is sustained without a combinational path from `ready_i` to the BRAM enable.

## Interface
- `RAM_WIDTH`, 8, data word width; must match the BRAM.
- `RAM_ADDR_BITS`, 10, BRAM address width; depth `DEPTH = 2**RAM_ADDR_BITS`.

- `clk_i` in 1: single clock, shared with the BRAM read port.
- `rst_i` in 1: reset, asynchronous, active-high.
- `start_i` in 1: start command; accepted only when idle (`busy_o=0`).
- `base_addr_i` in RAM_ADDR_BITS: first address, sampled with the accepted start.
- `len_i` in RAM_ADDR_BITS+1: word count 0..DEPTH, sampled with the accepted start.
- `busy_o` out 1: transfer in progress.
- `done_o` out 1: one-cycle pulse at transfer end.
- `ram_en_o` out 1: BRAM read enable.
- `ram_addr_o` out RAM_ADDR_BITS: BRAM read address.
- `ram_data_i` in RAM_WIDTH: BRAM read data, valid the cycle after `ram_en_o`.
- `data_o` out RAM_WIDTH: stream data.
- `valid_o` out 1: stream valid.
- `ready_i` in 1: stream ready.
- `last_o` out 1: marks the final word of a transfer.

## Operation
- FSM states: IDLE, READ.
  - IDLE→READ on `start_i` with `len_i≠0`.
  - IDLE stays IDLE on `start_i` with `len_i=0`, and pulses `done_o` the next cycle. No stream output.
  - READ→IDLE on the edge where the final word handshakes (`valid_o & ready_i & last_o`).
- `start_i` while busy is ignored, and the inputs are not resampled.
- Request counter `req_left` is loaded with `len_i`. Return counter `out_left` is also loaded with `len_i`.
- The address register is loaded with `base_addr_i` and increments modulo DEPTH. Wrap from DEPTH-1 to 0 is legal.
- Issue rule: `ram_en_o=1` when in READ, `req_left>0`, and `fifo_count + inflight < 3`.
  - `inflight` is a 1-bit flag set by an issued read. It is cleared when the word is written into the FIFO the following cycle.
  - The issue rule uses registered state only; it never depends on `ready_i`.
- Prefetch FIFO holds 3 entries. A returning word is written on the edge after its `ram_en_o` cycle. A FIFO overflow is impossible by construction.
- Stream output:
  - `valid_o = fifo not empty`; `data_o` = FIFO head.
  - A word pops on `valid_o & ready_i`.
  - `last_o = valid_o & (out_left==1)`.
  - `out_left` decrements per pop.
- `data_o` and `valid_o` are held stable while `valid_o & !ready_i`.
- `len_i = DEPTH` reads every address exactly once, starting at `base_addr_i`.
- `done_o` is registered. It is high for the one cycle after the last handshake edge (or after the zero-length start). `busy_o` is already 0 in that cycle, and a new `start_i` is accepted in it.
- Reset (any time, including mid-transfer):
  - State returns to IDLE.
  - Counters, FIFO pointers and `inflight` are cleared. A pending BRAM read result is discarded.
  - Outputs `busy_o`, `done_o`, `ram_en_o`, `valid_o` and `last_o` are 0. `ram_addr_o` and `data_o` are 0.

## Timing
- Start accepted at edge E0. Then:
  - Cycle 1: `busy_o=1`, `ram_en_o=1`, `ram_addr_o=base`.
  - Cycle 2: `ram_data_i` carries `mem[base]`.
  - Cycle 3: first `valid_o=1`.
- With `ready_i` held high, one word per cycle from cycle 3. An N-word transfer ends with its last handshake in cycle N+2 and `done_o` in cycle N+3.
- Backpressure: reads stall once FIFO plus in-flight reaches 3. Issue resumes the cycle after a pop frees space, with no data loss or duplication.

## Structure
- Package `bram_stream_pkg` contains:
  - `typedef enum logic {IDLE, READ} rd_state_t`.
  - `localparam PREFETCH_DEPTH = 3`.
- Sub-module `bram_rd_fifo`: synchronous FIFO with parameters `WIDTH` and `DEPTH`; signals push, pop, count, empty, full; same async reset.
- Top level: FSM, counters, address generator, inflight flag.

## Test plan
- Basic burst: BRAM preloaded `mem[a]=a[7:0]`, `base=5`, `len=4`, `ready_i=1` → stream 5,6,7,8 in cycles 3–6; `last_o` with 8; `done_o` in cycle 7; `ram_en_o` high in cycles 1–4 only.
- Wrap-around: `base=1022`, `len=4` → stream 0xFE, 0xFF, 0x00, 0x01; `ram_addr_o` sequence 1022, 1023, 0, 1.
- Backpressure: `len=8`, `ready_i` random (≥30% low) → exactly `mem[base..base+7]` in order, no duplicates; `data_o` stable while stalled; `fifo_count + inflight` never exceeds 3.
- Zero length and ignored start: `len=0` → no `valid_o`, `done_o` the cycle after start. `start_i` pulsed mid-transfer → no effect on the address sequence or the count.
- Reset mid-transfer: assert `rst_i` asynchronously during word 3 of 10 → all outputs 0 immediately. A new start (`base=0`, `len=2`) then yields exactly 0x00, 0x01, with no stale word.
- Full-depth read: `len=1024`, `base=512`, `ready_i=1` → 1024 words at 1/cycle, `last_o` on `mem[511]`, `done_o` in cycle 1027.
